// File: rtl/sm_intc_pkg.sv
// Shared definitions for the sm_intc external interrupt controller:
// register word indexes, address width and VECTOR valid bit position.
package sm_intc_pkg;

  localparam int unsigned INTC_ADDR_W        = 3;
  localparam int unsigned INTC_VEC_VALID_BIT = 31;

  typedef enum logic [INTC_ADDR_W-1:0] {
    INTC_REG_PENDING  = 3'd0,
    INTC_REG_MASK     = 3'd1,
    INTC_REG_EDGE     = 3'd2,
    INTC_REG_POLARITY = 3'd3,
    INTC_REG_VECTOR   = 3'd4,
    INTC_REG_RAW      = 3'd5
  } intc_reg_e;

  function automatic logic intcWrHit(input logic sel, input logic we,
                                     input logic [INTC_ADDR_W-1:0] addr,
                                     input intc_reg_e idx);
    return sel & we & (addr == idx);
  endfunction

endpackage

// File: rtl/sm_intc_if.sv
// Register access bus between the CPU data path and sm_intc.
interface sm_intc_if;
  import sm_intc_pkg::*;

  logic                   sel;
  logic [INTC_ADDR_W-1:0] addr;
  logic                   we;
  logic [31:0]            wd;
  logic [31:0]            rd;

  modport master (output sel, output addr, output we, output wd, input rd);
  modport slave  (input sel, input addr, input we, input wd, output rd);
endinterface

// File: rtl/sm_intc_src.sv
// One interrupt source slice: optional synchronizer (SM_CONFIG_INTC_SYNC_EN),
// polarity, conditioning pipeline, event detect and the pending bit.
module sm_intc_src (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic pol,
  input  logic edgeMode,
  input  logic clr,
  output logic inQ,
  output logic pendNext,
  output logic pending
);

  logic srcS;
  logic inQQ;
  logic evt;

`ifdef SM_CONFIG_INTC_SYNC_EN
  logic [1:0] syncQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) syncQ <= '0;
    else        syncQ <= {syncQ[0], src};
  end

  assign srcS = syncQ[1];
`else
  assign srcS = src;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inQ     <= 1'b0;
      inQQ    <= 1'b0;
      pending <= 1'b0;
    end else begin
      inQ     <= srcS ^ pol;
      inQQ    <= inQ;
      pending <= pendNext;
    end
  end

  // A new edge outranks a same-cycle W1C; level bits simply follow in_q.
  always_comb begin
    evt      = inQ & ~inQQ;
    pendNext = edgeMode ? (evt | (pending & ~clr)) : inQ;
  end

endmodule

// File: rtl/sm_intc.sv
// External interrupt controller in front of CP0: MASK/EDGE/POLARITY storage,
// priority encoder, register read mux and the intc_irq (cp0_ExcIP2) flop.
module sm_intc
  import sm_intc_pkg::*;
#(
  parameter int unsigned N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_src,
  sm_intc_if.slave         bus,
  output logic             intc_irq
);

  logic [N_IRQ-1:0] maskQ, edgeQ, polQ, maskNext;
  logic [N_IRQ-1:0] pending, pendNext, inQ, active, clrBits, wdN;
  logic             wrPend, wrMask, wrEdge, wrPol;
  logic [4:0]       vecIdx;
  logic             found;
  logic [31:0]      vector;
  logic [31:0]      unusedWd;

  // Write-data bits at and above N_IRQ have no storage.
  assign unusedWd = bus.wd;
  assign wdN      = bus.wd[N_IRQ-1:0];

  assign wrPend = intcWrHit(bus.sel, bus.we, bus.addr, INTC_REG_PENDING);
  assign wrMask = intcWrHit(bus.sel, bus.we, bus.addr, INTC_REG_MASK);
  assign wrEdge = intcWrHit(bus.sel, bus.we, bus.addr, INTC_REG_EDGE);
  assign wrPol  = intcWrHit(bus.sel, bus.we, bus.addr, INTC_REG_POLARITY);

  assign maskNext = wrMask ? wdN : maskQ;
  assign clrBits  = wrPend ? wdN : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maskQ <= '0;
      edgeQ <= '0;
      polQ  <= '0;
    end else begin
      maskQ <= maskNext;
      if (wrEdge) edgeQ <= wdN;
      if (wrPol)  polQ  <= wdN;
    end
  end

  for (genvar g = 0; g < N_IRQ; g++) begin : gSrc
    sm_intc_src uSrc (
      .clk      (clk),
      .rst_n    (rst_n),
      .src      (irq_src[g]),
      .pol      (polQ[g]),
      .edgeMode (edgeQ[g]),
      .clr      (clrBits[g]),
      .inQ      (inQ[g]),
      .pendNext (pendNext[g]),
      .pending  (pending[g])
    );
  end

  // Registered from next-state values so a MASK write acts at its own edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) intc_irq <= 1'b0;
    else        intc_irq <= |(pendNext & maskNext);
  end

  assign active = pending & maskQ;

  always_comb begin
    vecIdx = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (active[i] && !found) begin
        vecIdx = 5'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    vector                     = '0;
    vector[INTC_VEC_VALID_BIT] = found;
    vector[4:0]                = vecIdx;
  end

  always_comb begin
    bus.rd = '0;
    case (bus.addr)
      INTC_REG_PENDING:  bus.rd = 32'(pending);
      INTC_REG_MASK:     bus.rd = 32'(maskQ);
      INTC_REG_EDGE:     bus.rd = 32'(edgeQ);
      INTC_REG_POLARITY: bus.rd = 32'(polQ);
      INTC_REG_VECTOR:   bus.rd = vector;
      INTC_REG_RAW:      bus.rd = 32'(inQ);
      default:           bus.rd = '0;
    endcase
  end

endmodule

// File: tb/tb_sm_intc.sv
// Scoreboard bench for sm_intc: reads push expected values, a negedge
// monitor pops and compares on every read strobe.
module tb_sm_intc;
  import sm_intc_pkg::*;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] irq_src;
  logic         intc_irq;

  sm_intc_if bus ();

  sm_intc #(.N_IRQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src  (irq_src),
    .bus      (bus),
    .intc_irq (intc_irq)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.sel && !bus.we) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read addr=%0d rd=%h", bus.addr, bus.rd);
      end else begin
        exp_t  e;
        string nm;
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        checks++;
        if (bus.rd !== e.rd) begin
          errors++;
          $display("FAIL %s rd got=%h exp=%h", nm, bus.rd, e.rd);
        end
        checks++;
        if (intc_irq !== e.irq) begin
          errors++;
          $display("FAIL %s intc_irq got=%b exp=%b", nm, intc_irq, e.irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.sel  = 1'b1;
    bus.we   = 1'b1;
    bus.addr = a;
    bus.wd   = d;
    tick();
    bus.sel  = 1'b0;
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e,
                    input logic ei, input string nm);
    exp_t x;
    x.rd  = e;
    x.irq = ei;
    expQ.push_back(x);
    nameQ.push_back(nm);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    tick();
    bus.sel  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    irq_src  = '0;
    bus.sel  = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.wd   = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, 1'b0, "reset_read");

    // Level source 2: two edges from input to PENDING/intc_irq
    wr(INTC_REG_MASK, 32'h04);
    wr(INTC_REG_EDGE, 32'h00);
    irq_src = 8'h04;
    rd(INTC_REG_PENDING, 32'h0, 1'b0, "lvl_before_k");
    rd(INTC_REG_PENDING, 32'h0, 1'b0, "lvl_after_k");
    rd(INTC_REG_PENDING, 32'h04, 1'b1, "lvl_after_k1");
    rd(INTC_REG_VECTOR, 32'h8000_0002, 1'b1, "lvl_vector");
    rd(INTC_REG_RAW, 32'h04, 1'b1, "lvl_raw");
    wr(INTC_REG_PENDING, 32'h04);
    rd(INTC_REG_PENDING, 32'h04, 1'b1, "lvl_w1c_no_effect");
    irq_src = 8'h00;
    rd(INTC_REG_PENDING, 32'h04, 1'b1, "drop_before_k");
    rd(INTC_REG_PENDING, 32'h04, 1'b1, "drop_after_k");
    rd(INTC_REG_PENDING, 32'h00, 1'b0, "drop_after_k1");

    // Edge source 0: pulse latches, W1C clears, same-cycle event wins
    wr(INTC_REG_MASK, 32'h01);
    wr(INTC_REG_EDGE, 32'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    rd(INTC_REG_PENDING, 32'h01, 1'b1, "edge_latched");
    tick();
    tick();
    rd(INTC_REG_PENDING, 32'h01, 1'b1, "edge_held");
    wr(INTC_REG_PENDING, 32'h01);
    rd(INTC_REG_PENDING, 32'h00, 1'b0, "edge_w1c");
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    rd(INTC_REG_PENDING, 32'h01, 1'b1, "edge_relatch");
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    wr(INTC_REG_PENDING, 32'h01);
    rd(INTC_REG_PENDING, 32'h01, 1'b1, "set_wins_over_w1c");
    wr(INTC_REG_PENDING, 32'h01);
    rd(INTC_REG_PENDING, 32'h00, 1'b0, "edge_w1c2");

    // Priority: sources 5 and 3
    wr(INTC_REG_MASK, 32'hFFFF_FFFF);
    rd(INTC_REG_MASK, 32'h0000_00FF, 1'b0, "mask_upper_ignored");
    wr(INTC_REG_EDGE, 32'h28);
    irq_src = 8'h28;
    tick();
    irq_src = 8'h00;
    tick();
    rd(INTC_REG_PENDING, 32'h28, 1'b1, "prio_pending");
    rd(INTC_REG_VECTOR, 32'h8000_0003, 1'b1, "prio_vec3");
    wr(INTC_REG_PENDING, 32'h08);
    rd(INTC_REG_VECTOR, 32'h8000_0005, 1'b1, "prio_vec5");
    rd(INTC_REG_PENDING, 32'h20, 1'b1, "prio_pending5");
    wr(INTC_REG_VECTOR, 32'hFFFF_FFFF);
    rd(INTC_REG_VECTOR, 32'h8000_0005, 1'b1, "vector_ro");
    wr(INTC_REG_PENDING, 32'h20);
    rd(INTC_REG_VECTOR, 32'h0, 1'b0, "vector_empty");
    rd(3'd6, 32'h0, 1'b0, "idx6_zero");
    rd(3'd7, 32'h0, 1'b0, "idx7_zero");

    // Falling-edge source 1, masked then unmasked
    wr(INTC_REG_MASK, 32'h00);
    irq_src = 8'h02;
    tick();
    tick();
    rd(INTC_REG_PENDING, 32'h02, 1'b0, "masked_still_pends");
    wr(INTC_REG_POLARITY, 32'h02);
    tick();
    tick();
    wr(INTC_REG_EDGE, 32'h02);
    rd(INTC_REG_PENDING, 32'h00, 1'b0, "pol_settled");
    irq_src = 8'h00;
    tick();
    tick();
    rd(INTC_REG_PENDING, 32'h02, 1'b0, "fall_latched");
    rd(INTC_REG_VECTOR, 32'h0, 1'b0, "fall_vec_masked");
    rd(INTC_REG_RAW, 32'h02, 1'b0, "fall_raw");
    wr(INTC_REG_PENDING, 32'h02);
    rd(INTC_REG_PENDING, 32'h00, 1'b0, "fall_cleared");
    irq_src = 8'h02;
    tick();
    tick();
    tick();
    rd(INTC_REG_PENDING, 32'h00, 1'b0, "rise_ignored");
    rd(INTC_REG_RAW, 32'h00, 1'b0, "rise_raw");
    irq_src = 8'h00;
    tick();
    tick();
    rd(INTC_REG_PENDING, 32'h02, 1'b0, "fall2_latched");
    wr(INTC_REG_MASK, 32'h02);
    rd(INTC_REG_PENDING, 32'h02, 1'b1, "unmask_raises");

    // Asynchronous reset while intc_irq is high, sampled before any clock edge
    rst_n = 1'b0;
    rd(INTC_REG_PENDING, 32'h0, 1'b0, "async_reset");
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, 1'b0, "post_reset_read");

    tick();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
